// File: rtl/hydro_level_ctrl_if.sv
// Sample/actuator bundle between the level sampler, hydro_level_ctrl and
// the actuator drivers.
//
// Handshake: smp_valid is a one-cycle strobe with no back-pressure. ms, ts
// and ct are meaningful only on a cycle where smp_valid=1 and are
// don't-care otherwise. Every strobed sample is consumed on the clock edge
// that ends that cycle. The controller can never stall the sampler.
interface hydro_level_ctrl_if;
    logic       smp_valid;
    logic [3:0] ms;
    logic [3:0] ts;
    logic [3:0] ct;
    logic       fault_clr;
    logic       pump_on;
    logic       drain_on;
    logic       fault;
    logic [2:0] state;
    logic       lvl_lt;
    logic       lvl_eq;
    logic       lvl_gt;

    // Sampler/test side: drives samples and fault clear, observes outputs.
    modport master (
        output smp_valid, ms, ts, ct, fault_clr,
        input  pump_on, drain_on, fault, state, lvl_lt, lvl_eq, lvl_gt
    );

    // Controller side.
    modport slave (
        input  smp_valid, ms, ts, ct, fault_clr,
        output pump_on, drain_on, fault, state, lvl_lt, lvl_eq, lvl_gt
    );
endinterface

// File: rtl/hydro_level_ctrl.sv
// Tank-level pump/drain controller. Each strobed sample is compared against
// a saturated tolerance band around the setpoint. A debounced FSM drives the
// fill pump or the drain valve. A no-progress timeout latches a sticky fault
// that only fault_clr releases. All outputs are decoded from registers.
module hydro_level_ctrl #(
    parameter int DEBOUNCE = 3,    // 1..15
    parameter int TIMEOUT  = 200   // 1..255
) (
    input logic               clk,
    input logic               rst,
    hydro_level_ctrl_if.slave lvl_bus
);

    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_HOLD  = 3'b001;
    localparam logic [2:0] ST_FILL  = 3'b010;
    localparam logic [2:0] ST_DRAIN = 3'b011;
    localparam logic [2:0] ST_FAULT = 3'b100;

    // Direction of the sample that last advanced the debounce run.
    localparam logic [1:0] DIR_NONE  = 2'd0;
    localparam logic [1:0] DIR_BELOW = 2'd1;
    localparam logic [1:0] DIR_ABOVE = 2'd2;

    localparam logic [3:0] DEB_CNT   = 4'(DEBOUNCE);
    localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT - 1);

    logic [2:0] r_state;
    logic [3:0] r_dcnt;
    logic [1:0] r_dir;
    logic [7:0] r_tcnt;
    logic [3:0] r_last_ms;
    logic       r_lvl_lt;
    logic       r_lvl_eq;
    logic       r_lvl_gt;

    logic [4:0] w_upper_sum;
    logic [3:0] w_upper;
    logic [3:0] w_lower;
    logic       w_below;
    logic       w_above;
    logic [3:0] w_dcnt_run;
    logic [1:0] w_dir_run;
    logic [2:0] w_next_state;
    logic       w_progress;
    logic       w_state_chg;
    logic [3:0] w_dcnt_next;
    logic [1:0] w_dir_next;
    logic [7:0] w_tcnt_next;

    // Tolerance band around the setpoint, clamped to the 4-bit level range.
    always_comb begin
        w_upper_sum = {1'b0, lvl_bus.ts} + {1'b0, lvl_bus.ct};
        w_upper     = w_upper_sum[4] ? 4'hF : w_upper_sum[3:0];
        w_lower     = (lvl_bus.ct > lvl_bus.ts) ? 4'h0 : (lvl_bus.ts - lvl_bus.ct);
        w_below     = (lvl_bus.ms < w_lower);
        w_above     = (lvl_bus.ms > w_upper);
    end

    // Debounce run length as the current sample would leave it. Gaps without
    // a strobe leave the run untouched. A state change clears it later on.
    always_comb begin
        w_dcnt_run = r_dcnt;
        w_dir_run  = r_dir;
        if (lvl_bus.smp_valid) begin
            if (w_below) begin
                w_dir_run = DIR_BELOW;
                if (r_dir == DIR_BELOW && r_dcnt != 4'd0) begin
                    w_dcnt_run = (r_dcnt == 4'hF) ? 4'hF : (r_dcnt + 4'd1);
                end else begin
                    w_dcnt_run = 4'd1;
                end
            end else if (w_above) begin
                w_dir_run = DIR_ABOVE;
                if (r_dir == DIR_ABOVE && r_dcnt != 4'd0) begin
                    w_dcnt_run = (r_dcnt == 4'hF) ? 4'hF : (r_dcnt + 4'd1);
                end else begin
                    w_dcnt_run = 4'd1;
                end
            end else begin
                w_dir_run  = DIR_NONE;
                w_dcnt_run = 4'd0;
            end
        end
    end

    // Next-state selection. Reaching the target beats timeout, and progress
    // beats timeout.
    always_comb begin
        w_next_state = r_state;
        w_progress   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (lvl_bus.smp_valid) begin
                    if (w_below) begin
                        w_next_state = ST_FILL;
                    end else if (w_above) begin
                        w_next_state = ST_DRAIN;
                    end else begin
                        w_next_state = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (lvl_bus.smp_valid && w_dcnt_run == DEB_CNT) begin
                    if (w_below) begin
                        w_next_state = ST_FILL;
                    end else if (w_above) begin
                        w_next_state = ST_DRAIN;
                    end
                end
            end
            ST_FILL: begin
                w_progress = lvl_bus.smp_valid && (lvl_bus.ms > r_last_ms);
                if (lvl_bus.smp_valid && lvl_bus.ms >= lvl_bus.ts) begin
                    w_next_state = ST_HOLD;
                end else if (!w_progress && r_tcnt == TOUT_LAST) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_DRAIN: begin
                w_progress = lvl_bus.smp_valid && (lvl_bus.ms < r_last_ms);
                if (lvl_bus.smp_valid && lvl_bus.ms <= lvl_bus.ts) begin
                    w_next_state = ST_HOLD;
                end else if (!w_progress && r_tcnt == TOUT_LAST) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (lvl_bus.fault_clr) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Counter updates. Every state change restarts both the debounce run
    // and the no-progress timer.
    always_comb begin
        w_state_chg = (w_next_state != r_state);
        w_dcnt_next = w_state_chg ? 4'd0 : w_dcnt_run;
        w_dir_next  = w_state_chg ? DIR_NONE : w_dir_run;
        if (w_state_chg) begin
            w_tcnt_next = 8'd0;
        end else if (r_state == ST_FILL || r_state == ST_DRAIN) begin
            w_tcnt_next = w_progress ? 8'd0 : (r_tcnt + 8'd1);
        end else begin
            w_tcnt_next = 8'd0;
        end
    end

    // State, counters, last sample and compare flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_dcnt    <= 4'd0;
            r_dir     <= DIR_NONE;
            r_tcnt    <= 8'd0;
            r_last_ms <= 4'd0;
            r_lvl_lt  <= 1'b0;
            r_lvl_eq  <= 1'b0;
            r_lvl_gt  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_dcnt  <= w_dcnt_next;
            r_dir   <= w_dir_next;
            r_tcnt  <= w_tcnt_next;
            if (lvl_bus.smp_valid) begin
                r_last_ms <= lvl_bus.ms;
                r_lvl_lt  <= (lvl_bus.ms <  lvl_bus.ts);
                r_lvl_eq  <= (lvl_bus.ms == lvl_bus.ts);
                r_lvl_gt  <= (lvl_bus.ms >  lvl_bus.ts);
            end
        end
    end

    // Moore outputs decoded from the registered state only.
    assign lvl_bus.pump_on  = (r_state == ST_FILL);
    assign lvl_bus.drain_on = (r_state == ST_DRAIN);
    assign lvl_bus.fault    = (r_state == ST_FAULT);
    assign lvl_bus.state    = r_state;
    assign lvl_bus.lvl_lt   = r_lvl_lt;
    assign lvl_bus.lvl_eq   = r_lvl_eq;
    assign lvl_bus.lvl_gt   = r_lvl_gt;

endmodule

// File: tb/tb_hydro_level_ctrl.sv
// Bench for hydro_level_ctrl: directed scenarios followed by random samples.
// Every cycle is checked against a behavioural model of the controller.
module tb_hydro_level_ctrl;

  localparam int DEB  = 3;
  localparam int TOUT = 10;

  localparam int S_IDLE  = 0;
  localparam int S_HOLD  = 1;
  localparam int S_FILL  = 2;
  localparam int S_DRAIN = 3;
  localparam int S_FAULT = 4;

  logic clk;
  logic rst;
  hydro_level_ctrl_if bus ();

  hydro_level_ctrl #(.DEBOUNCE(DEB), .TIMEOUT(TOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .lvl_bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Expected {state[2:0], pump, drain, fault, lt, eq, gt} after each edge.
  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Model state, expressed as a mode, the sample history in HOLD and the
  // clock edge of the last entry into FILL/DRAIN or of the last progress.
  int   m_state = S_IDLE;
  int   m_cyc = 0;
  int   m_ref_cyc = 0;
  int   m_last_ms = 0;
  bit   m_lt, m_eq, m_gt;
  int   hold_q[$];

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, m_cyc, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit sv, input int ms, input int ts,
                            input int ct, input bit clr);
    int nxt;
    int upper;
    int lower;
    int dir;
    int run;
    bit exit_now;
    logic [2:0] st;
    m_cyc++;
    if (r) begin
      m_state   = S_IDLE;
      m_last_ms = 0;
      m_lt = 0; m_eq = 0; m_gt = 0;
      hold_q.delete();
    end else begin
      upper = (ts + ct > 15) ? 15 : ts + ct;
      lower = (ct > ts) ? 0 : ts - ct;
      dir = 0;
      if (sv && ms < lower) dir = 1;
      if (sv && ms > upper) dir = 2;
      nxt = m_state;
      case (m_state)
        S_IDLE: if (sv) nxt = (dir == 1) ? S_FILL : (dir == 2) ? S_DRAIN : S_HOLD;
        S_HOLD: if (sv) begin
          hold_q.push_back(dir);
          run = 0;
          for (int i = hold_q.size() - 1; i >= 0; i--) begin
            if (dir == 0 || hold_q[i] != dir) break;
            run++;
          end
          if (dir != 0 && run == DEB) nxt = (dir == 1) ? S_FILL : S_DRAIN;
        end
        S_FILL, S_DRAIN: begin
          exit_now = sv && ((m_state == S_FILL) ? (ms >= ts) : (ms <= ts));
          if (exit_now) nxt = S_HOLD;
          else if (sv && ((m_state == S_FILL) ? (ms > m_last_ms) : (ms < m_last_ms)))
            m_ref_cyc = m_cyc;
          else if (m_cyc - m_ref_cyc == TOUT) nxt = S_FAULT;
        end
        S_FAULT: if (clr) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
      if (nxt != m_state) begin
        hold_q.delete();
        m_ref_cyc = m_cyc;
      end
      if (sv) begin
        m_last_ms = ms;
        m_lt = (ms < ts); m_eq = (ms == ts); m_gt = (ms > ts);
      end
      m_state = nxt;
    end
    st = 3'(m_state);
    exp_q.push_back({st, m_state == S_FILL, m_state == S_DRAIN, m_state == S_FAULT,
                     m_lt, m_eq, m_gt});
  endtask

  task automatic compare();
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 9'h1, 9'h0);
    end else begin
      e = exp_q.pop_front();
      check("state", {6'd0, bus.state}, {6'd0, e[8:6]});
      check("actuators", {6'd0, bus.pump_on, bus.drain_on, bus.fault}, {6'd0, e[5:3]});
      check("lvl_flags", {6'd0, bus.lvl_lt, bus.lvl_eq, bus.lvl_gt}, {6'd0, e[2:0]});
      check("pump_drain_excl", {8'd0, bus.pump_on & bus.drain_on}, 9'd0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit sv, input logic [3:0] ms,
                      input logic [3:0] ts, input logic [3:0] ct, input bit clr);
    rst           = r;
    bus.smp_valid = sv;
    bus.ms        = sv ? ms : 4'($urandom_range(0, 15));
    bus.ts        = sv ? ts : 4'($urandom_range(0, 15));
    bus.ct        = sv ? ct : 4'($urandom_range(0, 15));
    bus.fault_clr = clr;
    @(posedge clk);
    model_step(r, sv, int'(ms), int'(ts), int'(ct), clr);
    #1;
    compare();
  endtask

  task automatic smp(input logic [3:0] ms, input logic [3:0] ts, input logic [3:0] ct);
    step(1'b0, 1'b1, ms, ts, ct, 1'b0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 4'd9, 4'd3, 4'd1, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ms_r;
    logic [3:0] ts_r;
    logic [3:0] ct_r;
    rst = 1'b1;
    bus.smp_valid = 1'b0;
    bus.ms = 4'd0; bus.ts = 4'd0; bus.ct = 4'd0;
    bus.fault_clr = 1'b0;

    // Reset then fill, then target reached.
    do_reset();
    smp(4'd5, 4'd8, 4'd2);
    gap(2);
    smp(4'd8, 4'd8, 4'd2);

    // Debounce in HOLD with an in-band sample breaking the first run.
    smp(4'd11, 4'd8, 4'd2); gap(1);
    smp(4'd11, 4'd8, 4'd2);
    smp(4'd7,  4'd8, 4'd2); gap(2);
    smp(4'd11, 4'd8, 4'd2);
    smp(4'd11, 4'd8, 4'd2); gap(3);
    smp(4'd11, 4'd8, 4'd2);
    gap(1);
    smp(4'd8, 4'd8, 4'd2);

    // Direction change restarts the run.
    smp(4'd11, 4'd8, 4'd2);
    smp(4'd11, 4'd8, 4'd2);
    smp(4'd3,  4'd8, 4'd2);
    smp(4'd3,  4'd8, 4'd2);
    smp(4'd3,  4'd8, 4'd2);
    smp(4'd8,  4'd8, 4'd2);

    // Saturated band edges never leave HOLD.
    for (int i = 0; i < 4; i++) smp(4'd15, 4'd14, 4'd3);
    for (int i = 0; i < 4; i++) smp(4'd0, 4'd1, 4'd3);

    // fault_clr in HOLD has no effect.
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    step(1'b0, 1'b1, 4'd8, 4'd8, 4'd2, 1'b1);

    // Timeout from FILL with a constant level.
    do_reset();
    smp(4'd4, 4'd12, 4'd2);
    for (int i = 0; i < 13; i++) smp(4'd4, 4'd12, 4'd2);

    // Fault recovery with a coincident sample, then a fresh fill.
    step(1'b0, 1'b1, 4'd2, 4'd12, 4'd2, 1'b1);
    smp(4'd2, 4'd12, 4'd2);

    // Progress part way through delays the timeout.
    do_reset();
    smp(4'd4, 4'd12, 4'd2);
    for (int i = 0; i < 4; i++) smp(4'd4, 4'd12, 4'd2);
    smp(4'd5, 4'd12, 4'd2);
    for (int i = 0; i < 12; i++) smp(4'd5, 4'd12, 4'd2);
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);

    // Timeout from DRAIN with no samples at all.
    smp(4'd14, 4'd5, 4'd2);
    gap(12);
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);

    // Reset in the middle of DRAIN.
    smp(4'd14, 4'd8, 4'd2);
    gap(2);
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);

    // Target reached on the very edge the timeout would fire.
    smp(4'd4, 4'd12, 4'd2);
    gap(TOUT - 1);
    smp(4'd12, 4'd12, 4'd2);
    gap(2);

    // Randomized traffic with a sticky level so that timeouts occur.
    ms_r = 4'd7; ts_r = 4'd8; ct_r = 4'd2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) ms_r = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 5) == 0) ms_r = ms_r + 4'd1;
      else if ($urandom_range(0, 5) == 0) ms_r = ms_r - 4'd1;
      if ($urandom_range(0, 40) == 0) ts_r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) ct_r = 4'($urandom_range(0, 5));
      step($urandom_range(0, 300) == 0, $urandom_range(0, 1) == 1,
           ms_r, ts_r, ct_r, $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hydro_level_ctrl.md
# hydro_level_ctrl

Sequential pump/drain controller for the tank-level datapath. On each level sample it builds a tolerance band from the setpoint and tolerance using 4-bit add/subtract with saturation, and compares the measured level against that band. A debounced state machine then drives the fill pump or drain valve, with a no-progress timeout that latches a fault. It sits between the level sensor sampler and the actuator drivers.

## Interface
Parameters:
- DEBOUNCE, default 3: consecutive out-of-band samples needed to leave HOLD. Legal range 1..15.
- TIMEOUT, default 200: clock cycles allowed in FILL/DRAIN without level progress before FAULT. Legal range 1..255.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- smp_valid  in  1  one-cycle strobe: ms/ts/ct are valid this cycle.
- ms  in  4  measured level, unsigned.
- ts  in  4  target setpoint, unsigned.
- ct  in  4  tolerance, unsigned.
- fault_clr  in  1  clears FAULT; ignored in any other state.
- pump_on  out  1  fill pump enable.
- drain_on  out  1  drain valve enable.
- fault  out  1  sticky fault indicator.
- state  out  3  encoding: IDLE=000, HOLD=001, FILL=010, DRAIN=011, FAULT=100.
- lvl_lt, lvl_eq, lvl_gt  out  1 each  registered ms-vs-ts compare from the last sample.

## Operation
- Band computation on each sample:
  - upper = ts+ct in 5 bits; if bit4 is set, upper saturates to 15.
  - lower = ts−ct; if ct>ts, lower saturates to 0.
  - below = ms<lower; above = ms>upper.
- Sample evaluation happens only on cycles with smp_valid=1. ms/ts/ct are don't-care otherwise.
- Debounce counter dcnt (4 bits):
  - Increments on a below sample if the previous counted sample was also below; same rule for above.
  - Loads 1 on a direction change. Clears on an in-band sample.
  - Clears on any state change.
- IDLE: first sample moves to FILL if below, DRAIN if above, else HOLD. No debounce applies.
- HOLD: moves to FILL when dcnt reaches DEBOUNCE on below samples, and to DRAIN on above samples.
- FILL: pump_on=1.
  - A sample with ms≥ts moves to HOLD.
  - A sample with ms>last_ms counts as progress and clears tcnt.
- DRAIN: drain_on=1.
  - A sample with ms≤ts moves to HOLD.
  - Progress means ms<last_ms.
- Progress tracking: last_ms is loaded on every sample. tcnt (8 bits) counts every clock in FILL/DRAIN and clears on state entry. tcnt==TIMEOUT−1 with no exit that cycle moves to FAULT.
- FAULT:
  - pump_on=0, drain_on=0, fault=1.
  - Samples still update the lvl_* flags but never change state.
  - fault_clr=1 moves to IDLE.
- Outputs are Moore-decoded from the registered state. pump_on and drain_on are never both 1.
- Simultaneous events:
  - rst has priority over everything.
  - A target-reached sample has priority over timeout in the same cycle, so the move is to HOLD.
  - Progress and timeout in the same cycle: progress wins and tcnt clears.
  - fault_clr with smp_valid in FAULT: go to IDLE; the sample is not evaluated for state.
- Reset values:
  - state=IDLE.
  - pump_on=0, drain_on=0, fault=0.
  - lvl_lt=0, lvl_eq=0, lvl_gt=0.
  - dcnt=0, tcnt=0, last_ms=0.
- Reset mid-FILL/DRAIN: actuators drop the cycle after the reset edge. Nothing is retained.

## Timing
- All registers update on the rising clk edge.
- A sample at edge N updates state, lvl_* and counters at edge N. The new outputs are visible during cycle N+1, so latency is 1 cycle.
- HOLD→FILL needs exactly DEBOUNCE strobed samples. Gaps without smp_valid do not break the run.
- Timeout: entry into FILL/DRAIN at edge E with no progress and no exit means FAULT is visible after edge E+TIMEOUT.
- fault_clr at edge F: state=IDLE and fault=0 visible after edge F.
- No combinational path from inputs to outputs.

## Test plan
- Reset then fill: rst; ts=8, ct=2 (band 6..10). First sample ms=5 → FILL and pump_on=1 one cycle later. Next sample ms=8 → HOLD and pump_on=0.
- Debounce in HOLD: ts=8, ct=2, DEBOUNCE=3. Sample ms=11, then 11, then 7 (in band), then 11, 11, 11 → DRAIN only after the 6th sample; drain_on=1 the next cycle.
- Saturation: ts=14, ct=3 gives upper=15, so ms=15 never moves to DRAIN. ts=1, ct=3 gives lower=0, so ms=0 never moves to FILL. lvl_gt/lvl_lt still track against ts.
- Timeout: TIMEOUT=10, enter FILL with ms=4. Hold ms=4 on every sample → fault=1 and state=100 exactly 10 cycles after entry. Repeat with ms=4,5 at cycle 5 → no fault before cycle 15.
- Fault recovery: in FAULT, pulse fault_clr together with smp_valid, ms=2 → IDLE; the next sample with ms=2 goes to FILL. fault_clr asserted in HOLD → no effect.
- Reset mid-operation: assert rst during DRAIN with drain_on=1 → all outputs 0 and state=000 after that edge. Target-reached sample coinciding with the timeout cycle → HOLD, not FAULT.
